// File: rtl/axi_wr_master_if.sv
// axi_wr_master_if
//   AXI4 write-address, write-data and write-response channel bundle.
//   master modport : AW/W payload + valids out, readies in; B in, BREADY out.
//   slave  modport : mirror of master.
interface axi_wr_master_if;
    logic [3:0]  AWID;
    logic [63:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/axi_wr_master.sv
// axi_wr_master
//   Turns a single-cycle store request from the memory stage into one
//   single-beat AXI4 write (AW + W + B). One store in flight at a time;
//   mm_wready stays low until the B response has been taken, so stores
//   retire in program order.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   mm_addr/mm_wdata  store byte address / LSB-aligned store data
//   mm_wlen           byte count 1/2/4/8 (anything else behaves as 8)
//   mm_wen            store request, held until accepted
//   mm_wready         high only while idle
//   mm_wdone          one-cycle pulse after the B handshake
//   axi               AXI write channels (master modport)
//   wr_err            sticky error flag
//   wr_err_addr       AWADDR of the first erroring write
//
// Build option
//   AXI_WR_RESP_CHECK_EN : when defined, non-OKAY BRESP sets wr_err and
//   captures wr_err_addr; otherwise both are tied to 0 and BRESP is ignored.
module axi_wr_master #(
    parameter logic [3:0] AWID_VAL = 4'd1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [63:0]          mm_addr,
    input  logic [63:0]          mm_wdata,
    input  logic [3:0]           mm_wlen,
    input  logic                 mm_wen,
    output logic                 mm_wready,
    output logic                 mm_wdone,
    axi_wr_master_if.master      axi,
    output logic                 wr_err,
    output logic [63:0]          wr_err_addr
);
    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t      state, state_nxt;
    logic        accept, aw_hs, w_hs, b_hs;
    logic        awvalid_q, wvalid_q, aw_done, w_done;
    logic [63:0] awaddr_q, wdata_q;
    logic [7:0]  wstrb_q;
    logic [2:0]  awsize_q;
    logic [7:0]  len_mask;
    logic [2:0]  size_dec;
    logic        bready;

    assign accept = mm_wen & mm_wready;
    assign aw_hs  = awvalid_q & axi.AWREADY;
    assign w_hs   = wvalid_q & axi.WREADY;
    assign b_hs   = bready & axi.BVALID;

    // Byte-count decode; unsupported counts fall through to a full doubleword.
    always_comb begin
        len_mask = 8'hFF;
        size_dec = 3'd3;
        case (mm_wlen)
            4'd1:    begin len_mask = 8'h01; size_dec = 3'd0; end
            4'd2:    begin len_mask = 8'h03; size_dec = 3'd1; end
            4'd4:    begin len_mask = 8'h0F; size_dec = 3'd2; end
            default: begin len_mask = 8'hFF; size_dec = 3'd3; end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Readiness and BREADY come straight from state so a reset drops them
    // without waiting for a clock edge.
    always_comb begin
        state_nxt = state;
        mm_wready = 1'b0;
        bready    = 1'b0;
        case (state)
            IDLE: begin
                mm_wready = 1'b1;
                if (mm_wen) state_nxt = SEND;
            end
            SEND: begin
                // A handshake in this cycle counts as done for the exit test.
                if ((aw_done | aw_hs) & (w_done | w_hs)) state_nxt = RESP;
            end
            RESP: begin
                bready = 1'b1;
                if (axi.BVALID) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awsize_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            mm_wdone  <= 1'b0;
        end else begin
            mm_wdone <= b_hs;
            if (accept) begin
                awaddr_q  <= mm_addr;
                awsize_q  <= size_dec;
                // Lanes past byte 7 are shifted out: no second beat is issued.
                wdata_q   <= mm_wdata << {mm_addr[2:0], 3'b000};
                wstrb_q   <= len_mask << mm_addr[2:0];
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                aw_done   <= 1'b0;
                w_done    <= 1'b0;
            end else begin
                if (aw_hs) begin
                    awvalid_q <= 1'b0;
                    aw_done   <= 1'b1;
                end
                if (w_hs) begin
                    wvalid_q <= 1'b0;
                    w_done   <= 1'b1;
                end
            end
        end
    end

    assign axi.AWID    = AWID_VAL;
    assign axi.AWADDR  = awaddr_q;
    assign axi.AWLEN   = 8'd0;
    assign axi.AWSIZE  = awsize_q;
    assign axi.AWBURST = 2'b01;
    assign axi.AWVALID = awvalid_q;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = wstrb_q;
    assign axi.WLAST   = wvalid_q;
    assign axi.WVALID  = wvalid_q;
    assign axi.BREADY  = bready;

`ifdef AXI_WR_RESP_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_err      <= 1'b0;
            wr_err_addr <= '0;
        end else if (b_hs && axi.BRESP != 2'b00) begin
            wr_err <= 1'b1;
            if (!wr_err) wr_err_addr <= awaddr_q;
        end
    end

    logic unused_ok;
    assign unused_ok = ^axi.BID;
`else
    assign wr_err      = 1'b0;
    assign wr_err_addr = '0;

    logic unused_ok;
    assign unused_ok = ^{axi.BID, axi.BRESP};
`endif
endmodule
